// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load scoreboard, load-use/capacity hazard detection,
// stall vector merge for the 5-stage core, stall statistics and wedge timeout.
module hazard_ctrl #(
  parameter int unsigned MAX_LOADS = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic        id_reg1_read_i,
  input  logic [4:0]  id_reg1_addr_i,
  input  logic        id_reg2_read_i,
  input  logic [4:0]  id_reg2_addr_i,
  input  logic        id_wreg_i,
  input  logic [4:0]  id_wd_i,
  input  logic        id_is_load_i,
  input  logic        ex_stallreq_i,
  input  logic        mem_stallreq_i,
  input  logic        ld_done_i,
  input  logic [4:0]  ld_wd_i,
  output logic [5:0]  stall_o,
  output logic [31:0] pending_o,
  output logic [15:0] stall_cnt_o,
  output logic        err_o
);

  localparam int unsigned NREG = 32;
  localparam int unsigned CW   = 6;
  localparam int unsigned SW   = 6;
  localparam int unsigned TW   = 16;

  localparam logic [SW-1:0] STALL_MEM = 6'b011111;
  localparam logic [SW-1:0] STALL_EX  = 6'b001111;
  localparam logic [SW-1:0] STALL_HAZ = 6'b000111;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    EXT  = 2'd1,
    LUSE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic [NREG-1:0]   done_mask, live, set_mask, clr_mask;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic [TW-1:0]     scnt_q, scnt_d;
  logic              err_q, err_d;
  logic              use_haz, cap_haz, ext_req, haz;
  logic              issue, clr, inc;
  logic [SW-1:0]     stall_c;

  // Hazard detection; a register completing this cycle is forwarded from MEM.
  always_comb begin
    done_mask = '0;
    if (ld_done_i) done_mask[ld_wd_i] = 1'b1;
    live    = pending_q & ~done_mask;
    live[0] = 1'b0;
    use_haz = id_valid_i & ((id_reg1_read_i & live[id_reg1_addr_i]) |
                            (id_reg2_read_i & live[id_reg2_addr_i]));
    cap_haz = id_valid_i & id_is_load_i & id_wreg_i & (cnt_q == CW'(MAX_LOADS));
    ext_req = mem_stallreq_i | ex_stallreq_i;
    haz     = use_haz | cap_haz;
    if (mem_stallreq_i)     stall_c = STALL_MEM;
    else if (ex_stallreq_i) stall_c = STALL_EX;
    else if (haz)           stall_c = STALL_HAZ;
    else                    stall_c = '0;
  end

  assign stall_o = rst ? stall_c : '0;

  // Scoreboard update; count tracks the number of set pending bits.
  always_comb begin
    issue    = id_valid_i & ~stall_c[2] & id_is_load_i & id_wreg_i & (id_wd_i != 5'd0);
    clr      = ld_done_i & pending_q[ld_wd_i];
    set_mask = '0;
    clr_mask = '0;
    if (issue) set_mask[id_wd_i] = 1'b1;
    if (clr)   clr_mask[ld_wd_i] = 1'b1;
    pending_d = (pending_q & ~clr_mask) | set_mask;
    inc = issue & (~pending_q[id_wd_i] | (clr & (ld_wd_i == id_wd_i)));
    cnt_d = cnt_q;
    if (inc & ~clr)
      cnt_d = cnt_q + CW'(1);
    else if (~inc & clr & (cnt_q != CW'(0)))
      cnt_d = cnt_q - CW'(1);
  end

  // Stall-source FSM plus wait/timeout and statistics counters.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (ext_req)  state_d = EXT;
        else if (haz) state_d = LUSE;
      end
      EXT: begin
        if (ext_req)  state_d = EXT;
        else if (haz) state_d = LUSE;
        else          state_d = RUN;
      end
      LUSE: begin
        if (ext_req)  state_d = EXT;
        else if (haz) state_d = LUSE;
        else          state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    wait_d = wait_q;
    if (state_d == RUN)
      wait_d = '0;
    else if (wait_q != TW'(TIMEOUT))
      wait_d = wait_q + TW'(1);
    err_d = err_q | (wait_d == TW'(TIMEOUT));

    scnt_d = scnt_q;
    if ((stall_c != '0) && (scnt_q != '1))
      scnt_d = scnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      pending_q <= '0;
      cnt_q     <= '0;
      wait_q    <= '0;
      scnt_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      scnt_q    <= scnt_d;
      err_q     <= err_d;
    end
  end

  assign pending_o   = pending_q;
  assign stall_cnt_o = scnt_q;
  assign err_o       = err_q;

endmodule
